// File: rtl/rotate_shift_pipe.sv
// Pipelined barrel rotate/shift unit: one registered stage per amount bit, valid/ready handshake.
// Left ops run through the right-moving stages on a bit-reversed operand.
module rotate_shift_pipe #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned TAG_WIDTH  = 4,
  localparam int unsigned SHW       = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [SHW-1:0]        shift_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  out_zero
);

  localparam logic [2:0] OpRotr = 3'b000;
  localparam logic [2:0] OpRotl = 3'b001;
  localparam logic [2:0] OpShr  = 3'b010;
  localparam logic [2:0] OpShl  = 3'b011;
  localparam logic [2:0] OpSra  = 3'b100;

  // Stage k keeps only amount bits k..SHW-1, packed as a triangle.
  function automatic int unsigned f_off(input int unsigned k);
    return k * SHW - (k * (k - 1)) / 2;
  endfunction

  localparam int unsigned AmtW = f_off(SHW);

  function automatic logic f_is_left(input logic [2:0] o);
    return (o == OpRotl) || (o == OpShl);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_rev(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = {<<{d}};
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_move(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [2:0] o, input logic msb,
                                                   input int unsigned sh);
    logic [DATA_WIDTH-1:0] fill;
    logic [DATA_WIDTH-1:0] r;
    fill = (o == OpSra && msb) ? ~({DATA_WIDTH{1'b1}} >> sh) : '0;
    case (o)
      OpRotr, OpRotl: r = (d >> sh) | (d << (DATA_WIDTH - sh));
      OpShr, OpShl:   r = d >> sh;
      OpSra:          r = (d >> sh) | fill;
      default:        r = d;
    endcase
    return r;
  endfunction

  logic                            w_adv;
  logic [SHW:0]                    r_vld;
  logic [SHW:0][DATA_WIDTH-1:0]    r_data;
  logic [SHW:0][DATA_WIDTH-1:0]    w_data;
  logic [SHW:0][TAG_WIDTH-1:0]     r_tag;
  logic [SHW-1:0][2:0]             r_op;
  logic [SHW-1:0]                  r_msb;
  logic [AmtW-1:0]                 r_amt;
  logic [AmtW-1:0]                 w_amt;
  logic                            r_zero;

  assign w_adv    = enable && (!r_vld[SHW] || out_ready);
  assign in_ready = w_adv;

  assign w_data[0]         = f_is_left(op) ? f_rev(a_in) : a_in;
  assign w_amt[0 +: SHW]   = shift_in;

  for (genvar k = 1; k <= SHW; k++) begin : g_stage
    localparam int unsigned Src = f_off(k - 1);
    localparam int unsigned Sh  = 1 << (k - 1);
    logic [DATA_WIDTH-1:0] w_moved;

    assign w_moved = r_amt[Src] ? f_move(r_data[k-1], r_op[k-1], r_msb[k-1], Sh) : r_data[k-1];

    if (k == SHW) begin : g_last
      assign w_data[k] = f_is_left(r_op[k-1]) ? f_rev(w_moved) : w_moved;
    end else begin : g_mid
      assign w_data[k]                  = w_moved;
      assign w_amt[f_off(k) +: SHW - k] = r_amt[Src + 1 +: SHW - k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_data <= '0;
      r_tag  <= '0;
      r_op   <= '0;
      r_msb  <= '0;
      r_amt  <= '0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_vld  <= {r_vld[SHW-1:0], in_valid};
      r_data <= w_data;
      r_tag  <= {r_tag[SHW-1:0], tag_in};
      r_op   <= {r_op[SHW-2:0], op};
      r_msb  <= {r_msb[SHW-2:0], a_in[DATA_WIDTH-1]};
      r_amt  <= w_amt;
      r_zero <= r_vld[SHW-1] && (w_data[SHW] == '0);
    end
  end

  assign out_valid = r_vld[SHW];
  assign a_out     = r_data[SHW];
  assign tag_out   = r_tag[SHW];
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_rotate_shift_pipe.sv
// Self-checking bench: 8-bit instance against a behavioural model plus 256-bit directed checks.
module tb_rotate_shift_pipe;

  localparam int S8 = 3;
  localparam int S2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable;
  logic       in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [2:0] op, shift_in;
  logic [7:0] a_in, a_out;
  logic [3:0] tag_in, tag_out;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
  logic [2:0]   b_op;
  logic [7:0]   b_shift_in;
  logic [255:0] b_a_in, b_a_out;
  logic [3:0]   b_tag_in, b_tag_out;

  rotate_shift_pipe #(.DATA_WIDTH(8), .TAG_WIDTH(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a_in(a_in), .shift_in(shift_in), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .a_out(a_out), .tag_out(tag_out), .out_zero(out_zero)
  );

  rotate_shift_pipe #(.DATA_WIDTH(256), .TAG_WIDTH(4)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op(b_op), .a_in(b_a_in), .shift_in(b_shift_in), .tag_in(b_tag_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .a_out(b_a_out), .tag_out(b_tag_out),
    .out_zero(b_out_zero)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_out = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the 8-bit operand.
  function automatic logic [7:0] model8(input logic [2:0] o, input logic [7:0] a, input int n);
    logic [15:0] dbl;
    dbl = {a, a};
    case (o)
      3'd0: begin dbl = dbl >> n; return dbl[7:0]; end
      3'd1: begin dbl = dbl << n; return dbl[15:8]; end
      3'd2: return a >> n;
      3'd3: return a << n;
      3'd4: return 8'($signed(a) >>> n);
      default: return a;
    endcase
  endfunction

  typedef struct {
    logic [7:0] d;
    logic [3:0] t;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && in_ready) begin
        if (q.size() == 0) check_eq("spurious_out", out_valid, 1'b0);
        else begin
          e = q.pop_front();
          check_eq("data", a_out, e.d);
          check_eq("tag", tag_out, e.t);
          check_eq("zero", out_zero, e.d == 8'd0);
          n_out++;
        end
      end
      if (in_valid && in_ready) q.push_back('{d: model8(op, a_in, shift_in), t: tag_in});
    end
  end

  task automatic offer(input logic [2:0] o, input logic [7:0] a, input logic [2:0] n,
                       input logic [3:0] t);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a_in = a; shift_in = n; tag_in = t;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic directed8(input string name, input logic [2:0] o, input logic [7:0] a,
                           input logic [2:0] n, input logic [7:0] exp);
    int t0, lat;
    offer(o, a, n, 4'h5);
    @(negedge clk);
    check_eq({name, "_accept"}, in_ready, 1'b1);
    t0 = cyc;
    idle();
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = cyc - t0 - 1; break; end
    end
    check_eq({name, "_lat"}, lat, S8);
    check_eq({name, "_data"}, a_out, exp);
  endtask

  task automatic directed256(input string name, input logic [2:0] o, input logic [255:0] a,
                             input logic [7:0] n, input logic [255:0] exp);
    int t0, lat;
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_op = o; b_a_in = a; b_shift_in = n; b_tag_in = 4'hC;
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b_out_valid) begin lat = cyc - t0 - 1; break; end
    end
    check_eq({name, "_lat"}, lat, S2);
    check_eq({name, "_data"}, b_a_out, exp);
    check_eq({name, "_tag"}, b_tag_out, 4'hC);
    check_eq({name, "_zero"}, b_out_zero, exp == '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int acc, cnt, first, last, n0;
  logic [255:0] top1;

  initial begin
    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; op = '0; a_in = '0; shift_in = '0; tag_in = '0;
    b_in_valid = 1'b0; b_op = '0; b_a_in = '0; b_shift_in = '0; b_tag_in = '0; b_out_ready = 1'b1;
    top1 = 256'd1 << 255;
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_a_out", a_out, 8'd0);
    check_eq("rst_tag_out", tag_out, 4'd0);
    check_eq("rst_out_zero", out_zero, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_b_out_valid", b_out_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    directed8("rotr81", 3'd0, 8'h81, 3'd1, 8'hC0);
    directed8("rotl81", 3'd1, 8'h81, 3'd1, 8'h03);
    directed8("shr80", 3'd2, 8'h80, 3'd3, 8'h10);
    directed8("shl81", 3'd3, 8'h81, 3'd7, 8'h80);
    directed8("sra80", 3'd4, 8'h80, 3'd3, 8'hF0);
    directed8("sra40", 3'd4, 8'h40, 3'd3, 8'h08);
    directed8("pass5a", 3'd6, 8'h5A, 3'd5, 8'h5A);
    directed8("shr_zero", 3'd2, 8'h01, 3'd1, 8'h00);

    directed256("w_rotr1", 3'd0, 256'd1, 8'd1, top1);
    directed256("w_shr1", 3'd2, 256'd1, 8'd1, 256'd0);
    directed256("w_rotl255", 3'd1, 256'd1, 8'd255, top1);
    directed256("w_sra255", 3'd4, top1, 8'd255, ~256'd0);
    directed256("w_shl255", 3'd3, 256'd3, 8'd255, top1);

    // Back-to-back random stream.
    acc = 0; cnt = 0; first = -1; last = -1;
    fork
      begin
        for (int i = 0; i < 20; i++)
          offer(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
        idle();
      end
      begin
        for (int i = 0; i < 20 + S8 + 6; i++) begin
          @(negedge clk);
          if (in_valid && in_ready) acc++;
          if (out_valid && in_ready) begin
            if (first < 0) first = cyc;
            last = cyc;
            cnt++;
          end
        end
      end
    join
    check_eq("stream_accepted", acc, 20);
    check_eq("stream_results", cnt, 20);
    check_eq("stream_span", last - first, 19);

    // Backpressure: fill, stall five cycles, release.
    n0 = n_out;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      offer(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)), 4'(i + 1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_out_valid", out_valid, 1'b1);
      if (q.size() > 0) begin
        check_eq("bp_hold_data", a_out, q[0].d);
        check_eq("bp_hold_tag", tag_out, q[0].t);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_accept", in_ready, 1'b1);
    idle();
    repeat (S8 + 4) @(negedge clk);
    check_eq("bp_results", n_out - n0, 5);
    check_eq("bp_drained", q.size(), 0);

    // Enable low mid-stream.
    for (int i = 0; i < 5; i++)
      offer(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)), 4'(i + 8));
    @(posedge clk); #1;
    enable = 1'b0;
    in_valid = 1'b1; op = 3'd0; a_in = 8'h3C; shift_in = 3'd2; tag_in = 4'hE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("en_in_ready", in_ready, 1'b0);
      check_eq("en_out_valid", out_valid, 1'b1);
      if (q.size() > 0) begin
        check_eq("en_hold_data", a_out, q[0].d);
        check_eq("en_hold_tag", tag_out, q[0].t);
      end
    end
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    check_eq("en_resume_accept", in_ready, 1'b1);
    idle();
    repeat (S8 + 4) @(negedge clk);
    check_eq("en_drained", q.size(), 0);

    // Reset with four operations in flight.
    for (int i = 0; i < 4; i++) offer(3'd7, 8'hA5, 3'd0, 4'(i + 3));
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_a_out", a_out, 8'd0);
    check_eq("mid_rst_tag_out", tag_out, 4'd0);
    check_eq("mid_rst_out_zero", out_zero, 1'b0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < S8 + 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_stale", out_valid, 1'b0);
    end
    directed8("post_rst_op", 3'd0, 8'h0F, 3'd4, 8'hF0);
    repeat (3) @(negedge clk);
    check_eq("final_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
